// File: rtl/reg_read_stage.sv
// Register-read stage: resolves operands from the PRF or same-cycle writeback bypass and holds them for execute.
// Latency: one cycle from accept to ex_valid when the output register is empty or draining.
// Backpressure: output register plus one skid entry; iss_ready is registered and drops only while the skid entry is held.
module reg_read_stage #(
    parameter int NUM_PREGS    = 64,
    parameter int NUM_EX_PIPES = 4,
    parameter int PAYLOAD_W    = 64,
    parameter int PREG_W       = $clog2(NUM_PREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,

    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic [PREG_W-1:0]            iss_src1_idx,
    input  logic [PREG_W-1:0]            iss_src2_idx,
    input  logic [PREG_W-1:0]            iss_dst_idx,
    input  logic [PAYLOAD_W-1:0]         iss_payload,

    output logic [PREG_W-1:0]            prf_src1_idx,
    output logic [PREG_W-1:0]            prf_src2_idx,
    input  logic [31:0]                  prf_src1_val,
    input  logic [31:0]                  prf_src2_val,

    input  logic [NUM_EX_PIPES-1:0]      byp_valid,
    input  logic [NUM_EX_PIPES*PREG_W-1:0] byp_idx,
    input  logic [NUM_EX_PIPES*32-1:0]   byp_val,

    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [31:0]                  ex_src1_val,
    output logic [31:0]                  ex_src2_val,
    output logic [PREG_W-1:0]            ex_dst_idx,
    output logic [PAYLOAD_W-1:0]         ex_payload
);

    typedef struct packed {
        logic [31:0]           src1;
        logic [31:0]           src2;
        logic [PREG_W-1:0]     dst;
        logic [PAYLOAD_W-1:0]  payload;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     state;
    entry_t     out_q;
    entry_t     skid_q;
    logic       out_valid;
    logic       skid_valid;
    logic       iss_ready_q;

    logic [31:0] src1_res;
    logic [31:0] src2_res;
    logic        hit1;
    logic        hit2;
    logic        byp_dup;
    entry_t      new_entry;
    logic        accept;
    logic        drain;

    assign prf_src1_idx = iss_src1_idx;
    assign prf_src2_idx = iss_src2_idx;

    // Lowest-numbered matching pipe wins; the PRF has not yet seen this cycle's writes.
    always_comb begin
        src1_res = prf_src1_val;
        src2_res = prf_src2_val;
        hit1     = 1'b0;
        hit2     = 1'b0;
        for (int i = 0; i < NUM_EX_PIPES; i++) begin
            if (!hit1 && byp_valid[i] && byp_idx[i*PREG_W +: PREG_W] == iss_src1_idx) begin
                src1_res = byp_val[i*32 +: 32];
                hit1     = 1'b1;
            end
            if (!hit2 && byp_valid[i] && byp_idx[i*PREG_W +: PREG_W] == iss_src2_idx) begin
                src2_res = byp_val[i*32 +: 32];
                hit2     = 1'b1;
            end
        end
        if (iss_src1_idx == '0) src1_res = '0;
        if (iss_src2_idx == '0) src2_res = '0;
    end

    always_comb begin
        byp_dup = 1'b0;
        for (int i = 0; i < NUM_EX_PIPES; i++) begin
            for (int j = i + 1; j < NUM_EX_PIPES; j++) begin
                if (byp_valid[i] && byp_valid[j]
                    && byp_idx[i*PREG_W +: PREG_W] == byp_idx[j*PREG_W +: PREG_W]
                    && byp_idx[i*PREG_W +: PREG_W] != '0)
                    byp_dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!byp_dup)
                else $warning("duplicate writeback to the same preg in one cycle");
        end
    end

    always_comb begin
        new_entry.src1    = src1_res;
        new_entry.src2    = src2_res;
        new_entry.dst     = iss_dst_idx;
        new_entry.payload = iss_payload;
    end

    assign accept = iss_valid && iss_ready_q && !flush;
    assign drain  = out_valid && ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            iss_ready_q <= 1'b1;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state       <= ST_EMPTY;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            iss_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q     <= new_entry;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_q <= new_entry;
                    end else if (accept) begin
                        skid_q      <= new_entry;
                        skid_valid  <= 1'b1;
                        iss_ready_q <= 1'b0;
                        state       <= ST_FULL;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        out_q       <= skid_q;
                        skid_valid  <= 1'b0;
                        iss_ready_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    out_valid   <= 1'b0;
                    skid_valid  <= 1'b0;
                    iss_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign iss_ready   = iss_ready_q;
    assign ex_valid    = out_valid;
    assign ex_src1_val = out_q.src1;
    assign ex_src2_val = out_q.src2;
    assign ex_dst_idx  = out_q.dst;
    assign ex_payload  = out_q.payload;

endmodule
